pipe_skid_reg: RTL and testbench
================================

# pipe_skid_reg

Parametrised successor to the two-output stage register of the multicycle datapath. It carries N channels of M-bit data between pipeline stages and adds a valid/ready handshake, so a stage can stall without losing data. A two-entry skid buffer keeps the upstream ready signal registered, so no combinational path runs from out_ready to in_ready. It sits between stages wherever a stall or flush must be absorbed.

## Interface
- M, 32, data width per channel
- N, 2, channel count (N ≥ 1); buses are flattened, channel k occupies bits [k*M +: M]
- CLK  input  1  clock; all state changes on posedge
- RST_N  input  1  reset, synchronous, active-low
- flush  input  1  synchronous discard of all held entries
- in_valid  input  1  upstream has data on d
- in_ready  output  1  stage can accept; a function of state only (registered)
- d  input  N*M  incoming channel data
- out_valid  output  1  q holds a valid entry
- out_ready  input  1  downstream accepts q this cycle
- q  output  N*M  head entry data
- level  output  2  entries held: 0, 1 or 2

## Operation
- Storage consists of a main register (head, drives q) and a skid register, each N*M bits, plus a state register.
- Per-cycle events:
  - accept = in_valid & in_ready
  - take = out_valid & out_ready
- States and transitions, for non-reset and non-flush cycles:
  - EMPTY (level 0, out_valid 0, in_ready 1):
    - accept: main←d, go to ONE
    - otherwise stay
  - ONE (level 1, out_valid 1, in_ready 1):
    - accept & !take: skid←d, go to FULL
    - accept & take: main←d, stay in ONE
    - !accept & take: go to EMPTY
    - neither: hold
  - FULL (level 2, out_valid 1, in_ready 0):
    - take: main←skid, go to ONE
    - otherwise hold
    - accept cannot occur in FULL.
- All N channels move together. There is no per-channel enable.
- Order is strictly FIFO. No entry is duplicated or dropped except by flush.
- Flush:
  - The next state is EMPTY regardless of the current state.
  - An accept in the same cycle is discarded.
  - A take in the same cycle completes: downstream consumes q as presented.
  - Data registers are not cleared; q keeps its last value, and q is don't-care while out_valid is 0.
- Reset (RST_N=0 at a posedge):
  - Takes priority over flush and over all handshakes.
  - state←EMPTY, main←0, skid←0.
- Outputs are derived only from registers: out_valid, in_ready and level decode the state, and q = main.

## Timing
- Reset values: out_valid 0, in_ready 1, level 0, q 0.
- Latency: data accepted at edge t is on q with out_valid=1 after edge t.
- Throughput: one entry per cycle while out_ready is held high, and level stays ≤1.
- Backpressure: when out_ready drops, one more entry is absorbed into skid. in_ready falls after that edge.
- Release: the first take in FULL restores in_ready=1 after that edge.
- Held data: q and out_valid stay stable while out_valid=1 and out_ready=0. Upstream keeps d stable while in_valid=1 and in_ready=0.
- Reset asserted mid-transfer:
  - Held entries are lost.
  - The first cycle after reset is EMPTY with in_ready=1.

## Test plan
- Reset with in_valid=1 and d=all-ones:
  - After the reset edge: out_valid=0, in_ready=1, level=0, q=0.
  - After RST_N rises: the first accepted word appears on q one edge later.
- Streaming, N=2, M=32:
  - Stimulus: send {0x1,0x2}, {0x3,0x4}, {0x5,0x6} back-to-back with out_ready=1.
  - Required: q shows them on three consecutive cycles, level=1 throughout, and in_ready never drops.
- Backpressure:
  - Stimulus: send A=0xA0, B=0xB0, C=0xC0 with out_ready=0.
  - Required: after accepting A and B, level=2 and in_ready=0. C is held upstream. q=A stays stable.
  - Stimulus: then raise out_ready.
  - Required: q shows A, B, C in order, with no loss or duplication.
- Simultaneous accept and take in ONE (q=0x11, d=0x22):
  - Required: after the edge q=0x22 and level stays 1.
- Flush in FULL with accept pending:
  - Required: after the edge level=0, out_valid=0, in_ready=1.
  - The next accepted word 0x33 appears on q with no stale entries ahead of it.
- Randomised stall pattern, 1000 words:
  - Required: the scoreboard sees the output sequence equal to the input sequence.
  - Required: out_valid or in_ready never changes in the same cycle as the input that caused it (checked by asserting both are register-driven).

Source files
------------

// File: rtl/pipe_skid_reg.sv
// Valid/ready pipeline register for N channels of M bits, backed by a two-entry skid buffer.
// in_ready and out_valid decode the state register only, so out_ready has no combinational path to in_ready.
module pipe_skid_reg #(
    parameter int M = 32,
    parameter int N = 2
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*M-1:0] d,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*M-1:0] q,
    output logic [1:0]     level
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N*M-1:0] main_q, main_d;
    logic [N*M-1:0] skid_q, skid_d;
    logic           accept, take;

    assign out_valid = (state_q == ONE) || (state_q == FULL);
    assign in_ready  = (state_q != FULL);
    assign level     = state_q;
    assign q         = main_q;

    assign accept = in_valid & in_ready;
    assign take   = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // Data registers keep their contents; only the occupancy is discarded.
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = d;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && take) begin
                        main_d = d;
                    end else if (accept) begin
                        skid_d  = d;
                        state_d = FULL;
                    end else if (take) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (take) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed and randomised-stall bench for pipe_skid_reg; a negedge monitor checks
// every take against a scoreboard of accepted words and checks that outputs are register-driven.
module tb_pipe_skid_reg;

    localparam int M = 32;
    localparam int N = 2;
    localparam int W = N * M;

    logic         CLK = 1'b0;
    logic         RST_N, flush, in_valid, out_ready;
    logic [W-1:0] d;
    logic         in_ready, out_valid;
    logic [W-1:0] q;
    logic [1:0]   level;

    int           nvec = 0;
    int           nerr = 0;
    logic [W-1:0] sb[$];
    logic         snap_ov, snap_ir;

    pipe_skid_reg #(.M(M), .N(N)) dut (
        .CLK(CLK), .RST_N(RST_N), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .d(d),
        .out_valid(out_valid), .out_ready(out_ready), .q(q), .level(level)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Step to just after the next edge; inputs are then updated by the caller.
    task automatic cyc();
        @(posedge CLK);
        #2;
    endtask

    task automatic chk_st(input string name, input logic [1:0] lv, input logic ov, input logic ir);
        chk({name, ".level"}, W'(level), W'(lv));
        chk({name, ".out_valid"}, W'(out_valid), W'(ov));
        chk({name, ".in_ready"}, W'(in_ready), W'(ir));
    endtask

    always @(posedge CLK) begin
        #1;
        snap_ov = out_valid;
        snap_ir = in_ready;
    end

    // Inputs change 2 units after posedge; a combinational output path would show up here.
    always @(negedge CLK) begin
        logic [W-1:0] exp;
        if (RST_N === 1'b1) begin
            nvec++;
            if (snap_ov !== out_valid || snap_ir !== in_ready) begin
                nerr++;
                $display("FAIL reg_driven: out_valid %b->%b in_ready %b->%b within a cycle",
                         snap_ov, out_valid, snap_ir, in_ready);
            end
        end
        if (RST_N !== 1'b1) begin
            sb.delete();
        end else begin
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                nvec++;
                if (sb.size() == 0) begin
                    nerr++;
                    $display("FAIL sb_order: got %h with nothing outstanding, expected no take", q);
                end else begin
                    exp = sb.pop_front();
                    if (q !== exp) begin
                        nerr++;
                        $display("FAIL sb_order: got %h expected %h", q, exp);
                    end
                end
            end
            if (flush === 1'b1) sb.delete();
            else if (in_valid === 1'b1 && in_ready === 1'b1) sb.push_back(d);
        end
    end

    initial begin
        int sent;
        int cycles;
        logic acc;
        logic [W-1:0] ones;
        ones = '1;

        // Reset with upstream pushing all-ones.
        RST_N = 1'b0; flush = 1'b0; in_valid = 1'b1; d = ones; out_ready = 1'b0;
        cyc();
        chk_st("reset", 2'd0, 1'b0, 1'b1);
        chk("reset.q", q, '0);
        RST_N = 1'b1; d = 64'h0000_00AB_0000_00CD;
        cyc();
        chk_st("first", 2'd1, 1'b1, 1'b1);
        chk("first.q", q, 64'h0000_00AB_0000_00CD);
        in_valid = 1'b0; out_ready = 1'b1;
        cyc();
        chk_st("drain0", 2'd0, 1'b0, 1'b1);

        // Streaming with out_ready held high.
        in_valid = 1'b1; out_ready = 1'b1; d = {32'h1, 32'h2};
        cyc();
        chk("stream1.q", q, {32'h1, 32'h2}); chk_st("stream1", 2'd1, 1'b1, 1'b1);
        d = {32'h3, 32'h4};
        cyc();
        chk("stream2.q", q, {32'h3, 32'h4}); chk_st("stream2", 2'd1, 1'b1, 1'b1);
        d = {32'h5, 32'h6};
        cyc();
        chk("stream3.q", q, {32'h5, 32'h6}); chk_st("stream3", 2'd1, 1'b1, 1'b1);
        in_valid = 1'b0;
        cyc();
        chk_st("stream_end", 2'd0, 1'b0, 1'b1);

        // Backpressure: A and B absorbed, C held upstream.
        out_ready = 1'b0; in_valid = 1'b1; d = 64'hA0;
        cyc();
        chk("bp_a.q", q, 64'hA0); chk_st("bp_a", 2'd1, 1'b1, 1'b1);
        d = 64'hB0;
        cyc();
        chk("bp_b.q", q, 64'hA0); chk_st("bp_b", 2'd2, 1'b1, 1'b0);
        d = 64'hC0;
        cyc();
        chk("bp_hold.q", q, 64'hA0); chk_st("bp_hold", 2'd2, 1'b1, 1'b0);
        out_ready = 1'b1;
        cyc();
        chk("bp_rel.q", q, 64'hB0); chk_st("bp_rel", 2'd1, 1'b1, 1'b1);
        cyc();
        chk("bp_c.q", q, 64'hC0); chk_st("bp_c", 2'd1, 1'b1, 1'b1);
        in_valid = 1'b0;
        cyc();
        chk_st("bp_end", 2'd0, 1'b0, 1'b1);

        // Simultaneous accept and take in ONE.
        out_ready = 1'b0; in_valid = 1'b1; d = 64'h11;
        cyc();
        chk("sim_a.q", q, 64'h11);
        d = 64'h22; out_ready = 1'b1;
        cyc();
        chk("sim_b.q", q, 64'h22); chk_st("sim_b", 2'd1, 1'b1, 1'b1);
        in_valid = 1'b0;
        cyc();

        // Flush in FULL with upstream still presenting data.
        out_ready = 1'b0; in_valid = 1'b1; d = 64'h44;
        cyc();
        d = 64'h55;
        cyc();
        chk_st("pre_flush", 2'd2, 1'b1, 1'b0);
        flush = 1'b1; d = 64'h66;
        cyc();
        chk_st("flush_full", 2'd0, 1'b0, 1'b1);
        flush = 1'b0; d = 64'h33;
        cyc();
        chk("post_flush.q", q, 64'h33); chk_st("post_flush", 2'd1, 1'b1, 1'b1);
        in_valid = 1'b0; out_ready = 1'b1;
        cyc();
        chk_st("post_flush_drain", 2'd0, 1'b0, 1'b1);

        // Flush in ONE discards a same-cycle accept.
        out_ready = 1'b0; in_valid = 1'b1; d = 64'h77;
        cyc();
        flush = 1'b1; d = 64'h88;
        cyc();
        chk_st("flush_one", 2'd0, 1'b0, 1'b1);
        flush = 1'b0; in_valid = 1'b0;
        cyc();
        chk_st("flush_one_after", 2'd0, 1'b0, 1'b1);

        // Reset mid-transfer from FULL.
        in_valid = 1'b1; d = 64'h99;
        cyc();
        d = 64'hAA;
        cyc();
        RST_N = 1'b0;
        cyc();
        chk_st("mid_reset", 2'd0, 1'b0, 1'b1);
        chk("mid_reset.q", q, '0);
        RST_N = 1'b1; in_valid = 1'b0;
        cyc();
        chk_st("after_reset", 2'd0, 1'b0, 1'b1);

        // Random stalls, 1000 words; d held stable while not accepted.
        sent = 0; cycles = 0; in_valid = 1'b0;
        while ((sent < 1000 || sb.size() != 0) && cycles < 20000) begin
            acc = in_valid && in_ready;
            cyc();
            cycles++;
            if (acc) begin
                sent++;
                in_valid = 1'b0;
            end
            if (!in_valid && sent < 1000 && ($urandom % 4) != 0) begin
                in_valid = 1'b1;
                d = {$urandom(), $urandom()};
            end
            out_ready = (sent >= 1000) || (($urandom % 3) != 0);
        end
        chk("rand_done", W'(cycles < 20000), W'(1));
        chk("rand_sent", W'(sent), W'(1000));
        in_valid = 1'b0; out_ready = 1'b1;
        cyc(); cyc();
        chk("rand_drained", W'(sb.size()), W'(0));
        chk_st("final", 2'd0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
